// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master arbiter for the 16-bit CPU memory bus with tagged read return
module mem_arbiter #(
    parameter int RD_LATENCY = 1,
    parameter int MAX_HOLD   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] m0_addr,
    input  logic        m0_rd,
    input  logic        m0_wr,
    input  logic [15:0] m0_wrdata,
    output logic        m0_waitrequest,
    output logic [15:0] m0_rddata,
    output logic        m0_rdvalid,
    input  logic [15:0] m1_addr,
    input  logic        m1_rd,
    input  logic        m1_wr,
    input  logic [15:0] m1_wrdata,
    output logic        m1_waitrequest,
    output logic [15:0] m1_rddata,
    output logic        m1_rdvalid,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic [15:0] o_mem_wrdata,
    input  logic [15:0] i_mem_rddata
);

    localparam logic [3:0] MAX_HOLD_W = 4'(MAX_HOLD);

    logic                  req0;
    logic                  req1;
    logic                  grant0;
    logic                  grant1;
    logic                  winner;
    logic                  last_grant;
    logic [3:0]            hold_cnt;
    logic [RD_LATENCY-1:0] tag_v;
    logic [RD_LATENCY-1:0] tag_id;
    logic                  tail_v;
    logic                  tail_id;

    assign req0 = m0_rd | m0_wr;
    assign req1 = m1_rd | m1_wr;

    // hold_cnt == 0 means nobody owns the bus, so a tie goes to the requester not granted last
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        winner = ~last_grant;
        if (hold_cnt != 4'd0 && hold_cnt < MAX_HOLD_W) begin
            winner = last_grant;
        end
        if (reset_n) begin
            if (req0 && !req1) begin
                grant0 = 1'b1;
            end else if (req1 && !req0) begin
                grant1 = 1'b1;
            end else if (req0 && req1) begin
                grant0 = ~winner;
                grant1 = winner;
            end
        end
    end

    assign m0_waitrequest = ~reset_n | (req0 & ~grant0);
    assign m1_waitrequest = ~reset_n | (req1 & ~grant1);

    always_comb begin
        o_mem_addr   = 16'h0000;
        o_mem_wrdata = 16'h0000;
        o_mem_rd     = 1'b0;
        o_mem_wr     = 1'b0;
        if (grant0) begin
            o_mem_addr   = m0_addr;
            o_mem_wrdata = m0_wrdata;
            o_mem_rd     = m0_rd & ~m0_wr;
            o_mem_wr     = m0_wr;
        end else if (grant1) begin
            o_mem_addr   = m1_addr;
            o_mem_wrdata = m1_wrdata;
            o_mem_rd     = m1_rd & ~m1_wr;
            o_mem_wr     = m1_wr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
            hold_cnt   <= 4'd0;
        end else if (grant0 || grant1) begin
            if (grant1 == last_grant) begin
                hold_cnt <= (hold_cnt == 4'd15) ? 4'd15 : hold_cnt + 4'd1;
            end else begin
                hold_cnt   <= 4'd1;
                last_grant <= grant1;
            end
        end else begin
            hold_cnt <= 4'd0;
        end
    end

    // stage i holds the read issued i+1 edges ago; the last stage lines up with i_mem_rddata
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= o_mem_rd;
            tag_id[0] <= grant1;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign tail_v     = tag_v[RD_LATENCY-1];
    assign tail_id    = tag_id[RD_LATENCY-1];
    assign m0_rdvalid = tail_v & ~tail_id;
    assign m1_rdvalid = tail_v & tail_id;
    assign m0_rddata  = m0_rdvalid ? i_mem_rddata : 16'h0000;
    assign m1_rddata  = m1_rdvalid ? i_mem_rddata : 16'h0000;

endmodule
